// File: rtl/recon_icap_loader.sv
// Streams a configuration bitstream from AXI memory into the ICAP port.
// Bursts are sized to stay inside a 4 KiB page, and each word is bit-reversed per byte.
module recon_icap_loader #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDR_WIDTH    = 34,
  parameter int ID_WIDTH      = 6,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  icap_csib,
  output logic                  icap_rdwrb,
  output logic [31:0]           icap_o,
  input  logic                  icap_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  // state  | meaning
  // S_IDLE | waiting for a command
  // S_ADDR | presenting one AR burst
  // S_DATA | accepting beats and emitting words of the current burst
  // S_DONE | one-cycle completion pulse
  // S_ERR  | one-cycle completion pulse with error set

  localparam int WPB = DATA_WIDTH / 32;
  localparam int BPB = DATA_WIDTH / 8;
  localparam int BB  = $clog2(BPB);
  localparam int WIB = (WPB > 1) ? $clog2(WPB) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_DONE, S_ERR} state_t;
  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [31:0]           bytes_rem;
  logic [DATA_WIDTH-1:0] beat_buf;
  logic                  buf_valid;
  logic                  buf_last;
  logic [WIB-1:0]        buf_idx;
  logic                  err_drain;
  logic                  error_r;

  logic [ADDR_WIDTH-1:0] beat_addr;
  logic [32:0]           beats_left;
  logic [12:0]           beats_4k;
  logic [32:0]           blen;
  logic                  r_hs;
  logic                  r_bad;
  logic                  emit;
  logic                  last_word;

  function automatic logic [31:0] rev_bytes(input logic [31:0] w);
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        rev_bytes[b*8+i] = w[b*8+7-i];
  endfunction

  // cur_addr always points at the next word to emit, so it also drives burst sizing
  assign beat_addr  = cur_addr & ~ADDR_WIDTH'(BPB - 1);
  assign beats_left = ({1'b0, bytes_rem} + 33'(cur_addr[BB-1:0]) + 33'(BPB - 1)) >> BB;
  assign beats_4k   = (13'h1000 - {1'b0, beat_addr[11:0]}) >> BB;

  always_comb begin
    blen = 33'(MAX_BURST_LEN);
    if (beats_left < blen) blen = beats_left;
    if (33'(beats_4k) < blen) blen = 33'(beats_4k);
  end

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = beat_addr;
  assign m_axi_arlen   = 8'(blen - 33'd1);
  assign m_axi_arsize  = 3'(BB);
  assign m_axi_arburst = 2'b01;
  assign m_axi_arvalid = (state == S_ADDR);

  assign m_axi_rready = (state == S_DATA) && !buf_valid;
  assign r_hs         = m_axi_rvalid && m_axi_rready;
  assign r_bad        = r_hs && (err_drain || (m_axi_rresp != 2'b00));
  assign emit         = (state == S_DATA) && buf_valid && icap_ready;
  assign last_word    = (buf_idx == WIB'(WPB - 1)) || (bytes_rem == 32'd4);

  assign icap_csib  = !emit;
  assign icap_rdwrb = 1'b0;
  assign icap_o     = emit ? rev_bytes(32'(beat_buf >> {buf_idx, 5'd0})) : 32'd0;

  assign busy      = (state != S_IDLE);
  assign cmd_ready = (state == S_IDLE);
  assign done      = (state == S_DONE) || (state == S_ERR);
  assign error     = error_r;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if ((cmd_addr[1:0] != 2'b00) || (cmd_len[1:0] != 2'b00)) state_nxt = S_ERR;
          else if (cmd_len == 32'd0)                              state_nxt = S_DONE;
          else                                                    state_nxt = S_ADDR;
        end
      end
      S_ADDR: if (m_axi_arready) state_nxt = S_DATA;
      S_DATA: begin
        if (r_bad && m_axi_rlast)
          state_nxt = S_ERR;
        else if (emit && last_word && buf_last)
          state_nxt = (bytes_rem == 32'd4) ? S_DONE : S_ADDR;
      end
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cur_addr  <= '0;
      bytes_rem <= '0;
      beat_buf  <= '0;
      buf_valid <= 1'b0;
      buf_last  <= 1'b0;
      buf_idx   <= '0;
      err_drain <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == S_IDLE) && cmd_valid) begin
        cur_addr  <= cmd_addr;
        bytes_rem <= cmd_len;
        err_drain <= 1'b0;
        buf_valid <= 1'b0;
        error_r   <= 1'b0;
      end
      // a bad beat poisons the rest of the burst; later beats are drained but never buffered
      if (r_hs) begin
        if (r_bad) begin
          err_drain <= 1'b1;
        end else begin
          beat_buf  <= m_axi_rdata;
          buf_valid <= 1'b1;
          buf_last  <= m_axi_rlast;
          buf_idx   <= WIB'((cur_addr >> 2) & ADDR_WIDTH'(WPB - 1));
        end
      end
      if (emit) begin
        cur_addr  <= cur_addr + ADDR_WIDTH'(4);
        bytes_rem <= bytes_rem - 32'd4;
        if (last_word) buf_valid <= 1'b0;
        else           buf_idx   <= buf_idx + WIB'(1);
      end
      if (state_nxt == S_ERR) error_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_recon_icap_loader.sv
// Directed bench for recon_icap_loader: AXI read slave model plus ICAP word capture.
module tb_recon_icap_loader;
  localparam int DW = 64;
  localparam int AW = 34;
  localparam int IW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_len;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [IW-1:0] m_axi_arid;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic          m_axi_arvalid;
  logic          m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast;
  logic          m_axi_rvalid;
  logic          m_axi_rready;
  logic          icap_csib;
  logic          icap_rdwrb;
  logic [31:0]   icap_o;
  logic          icap_ready;
  logic          busy;
  logic          done;
  logic          error;

  always #5 clk = ~clk;

  recon_icap_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MAX_BURST_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
    .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .icap_csib(icap_csib), .icap_rdwrb(icap_rdwrb), .icap_o(icap_o), .icap_ready(icap_ready),
    .busy(busy), .done(done), .error(error)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // memory image: byte at address b holds b[7:0]+1
  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    logic [7:0] b0;
    b0 = a[7:0];
    return {b0 + 8'd4, b0 + 8'd3, b0 + 8'd2, b0 + 8'd1};
  endfunction

  function automatic logic [31:0] rev8(input logic [31:0] w);
    logic [31:0] r;
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 8; i++)
        r[b*8+i] = w[b*8+7-i];
    return r;
  endfunction

  logic [AW-1:0] q_addr[$];
  int            q_len[$];
  logic [AW-1:0] ar_addr_log[$];
  int            ar_len_log[$];
  logic [31:0]   got[$];
  int beat_n = 0, beat_global = 0, err_beat = -1;
  int done_cnt = 0, r_hs_cnt = 0;
  int ovl_viol = 0, csib_viol = 0, drain_low = 0, full_viol = 0;
  logic err_at_done = 1'b0;
  bit toggle_ready = 0, check_full = 0, drain_active = 0;
  bit pend_ar = 0, pend_r = 0;

  // AXI read slave, icap_ready driver and output monitor; samples 1 ns after the falling edge
  initial begin
    logic [AW-1:0] ba;
    m_axi_arready = 1'b1;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    icap_ready    = 1'b1;
    forever begin
      @(negedge clk);
      if (pend_ar) begin
        if (q_addr.size() != 0) ovl_viol++;
        ar_addr_log.push_back(m_axi_araddr);
        ar_len_log.push_back(int'(m_axi_arlen));
        q_addr.push_back(m_axi_araddr);
        q_len.push_back(int'(m_axi_arlen));
      end
      if (pend_r) begin
        if (check_full && (got.size() != 2 * r_hs_cnt)) full_viol++;
        r_hs_cnt++;
        if (m_axi_rresp != 2'b00 && !m_axi_rlast) drain_active = 1;
        if (m_axi_rlast) begin
          void'(q_addr.pop_front());
          void'(q_len.pop_front());
          beat_n = 0;
          drain_active = 0;
        end else begin
          beat_n++;
        end
        beat_global++;
      end
      if (rst) begin
        q_addr.delete();
        q_len.delete();
        beat_n = 0;
        drain_active = 0;
      end
      icap_ready = toggle_ready ? ~icap_ready : 1'b1;
      if (q_addr.size() != 0) begin
        ba = q_addr[0] + AW'(beat_n * 8);
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = {mem_word(ba + AW'(4)), mem_word(ba)};
        m_axi_rlast  = (beat_n == q_len[0]);
        m_axi_rresp  = (beat_global == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
      end
      #1;
      pend_ar = m_axi_arvalid && m_axi_arready && !rst;
      pend_r  = m_axi_rvalid && m_axi_rready && !rst;
      if (!icap_csib) got.push_back(icap_o);
      else if (icap_o != 32'd0) csib_viol++;
      if (done) begin
        done_cnt++;
        err_at_done = error;
      end
      if (drain_active && !m_axi_rready) drain_low++;
    end
  end

  task automatic run_cmd(input logic [AW-1:0] a, input logic [31:0] len, input int maxcyc,
                         output int waited);
    got.delete();
    ar_addr_log.delete();
    ar_len_log.delete();
    done_cnt    = 0;
    r_hs_cnt    = 0;
    beat_global = 0;
    cmd_addr  = a;
    cmd_len   = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    waited = 0;
    while (done_cnt == 0 && waited < maxcyc) begin
      @(negedge clk);
      waited++;
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic check_words(input string tag, input logic [AW-1:0] a, input int n);
    check({tag, "_nwords"}, 64'(got.size()), 64'(n));
    for (int i = 0; i < n && i < got.size(); i++)
      check($sformatf("%s_w%0d", tag, i), 64'(got[i]), 64'(rev8(mem_word(a + AW'(4 * i)))));
  endtask

  initial begin
    int w;
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr = '0;
    cmd_len = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    check("rst_busy",      64'(busy),      64'd0);
    check("rst_outputs",   64'({done, error, icap_csib, m_axi_arvalid, m_axi_rready}), 64'b00100);
    check("rst_icap_o",    64'(icap_o),    64'd0);
    @(negedge clk);

    // V1: single aligned burst
    check_full = 1;
    run_cmd(34'h1000, 32'd64, 500, w);
    check_full = 0;
    check("v1_done",  64'(done_cnt), 64'd1);
    check("v1_err",   64'(err_at_done), 64'd0);
    check("v1_nar",   64'(ar_addr_log.size()), 64'd1);
    if (ar_addr_log.size() >= 1) begin
      check("v1_araddr", 64'(ar_addr_log[0]), 64'h1000);
      check("v1_arlen",  64'(ar_len_log[0]), 64'd7);
    end
    if (got.size() >= 1) check("v1_first_word", 64'(got[0]), 64'h20C0_4080);
    check_words("v1", 34'h1000, 16);
    check("v1_rr_full", 64'(full_viol), 64'd0);
    check("v1_arsize_burst_id", 64'({m_axi_arsize, m_axi_arburst, m_axi_arid}), 64'({3'd3, 2'b01, 6'd0}));

    // V2: 4 KiB split
    run_cmd(34'h0FF8, 32'd32, 500, w);
    check("v2_done", 64'(done_cnt), 64'd1);
    check("v2_nar",  64'(ar_addr_log.size()), 64'd2);
    if (ar_addr_log.size() >= 2) begin
      check("v2_ar0", 64'({ar_addr_log[0], 8'(ar_len_log[0])}), 64'({34'h0FF8, 8'd0}));
      check("v2_ar1", 64'({ar_addr_log[1], 8'(ar_len_log[1])}), 64'({34'h1000, 8'd2}));
    end
    check_words("v2", 34'h0FF8, 8);

    // V3: offset start and trimmed tail
    run_cmd(34'h1004, 32'd8, 500, w);
    check("v3_done", 64'(done_cnt), 64'd1);
    check("v3_nar",  64'(ar_addr_log.size()), 64'd1);
    if (ar_addr_log.size() >= 1)
      check("v3_ar0", 64'({ar_addr_log[0], 8'(ar_len_log[0])}), 64'({34'h1000, 8'd1}));
    check_words("v3", 34'h1004, 2);

    // V4: SLVERR on the second beat
    err_beat = 1;
    run_cmd(34'h2000, 32'd64, 500, w);
    err_beat = -1;
    check("v4_done",      64'(done_cnt), 64'd1);
    check("v4_err",       64'(err_at_done), 64'd1);
    check("v4_sticky",    64'(error), 64'd1);
    check("v4_beats",     64'(r_hs_cnt), 64'd8);
    check("v4_drain_low", 64'(drain_low), 64'd0);
    check_words("v4", 34'h2000, 2);

    // misaligned length
    run_cmd(34'h1000, 32'd6, 50, w);
    check("mis_done", 64'(done_cnt), 64'd1);
    check("mis_err",  64'(err_at_done), 64'd1);
    check("mis_nar",  64'(ar_addr_log.size()), 64'd0);

    // V5: icap_ready toggling
    toggle_ready = 1;
    check_full = 1;
    run_cmd(34'h3000, 32'd256, 3000, w);
    toggle_ready = 0;
    check_full = 0;
    check("v5_done",    64'(done_cnt), 64'd1);
    check("v5_err_clr", 64'(error), 64'd0);
    check("v5_nar",     64'(ar_addr_log.size()), 64'd2);
    if (ar_addr_log.size() >= 2) begin
      check("v5_ar0", 64'({ar_addr_log[0], 8'(ar_len_log[0])}), 64'({34'h3000, 8'd15}));
      check("v5_ar1", 64'({ar_addr_log[1], 8'(ar_len_log[1])}), 64'({34'h3080, 8'd15}));
    end
    check_words("v5", 34'h3000, 64);
    check("v5_rr_full", 64'(full_viol), 64'd0);

    // V6: reset mid-DATA, then zero-length command
    got.delete();
    cmd_addr = 34'h4000;
    cmd_len = 32'd64;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while (got.size() < 3 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check("v6_reached_data", 64'(got.size() >= 3), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("v6_rst_outputs", 64'({m_axi_arvalid, m_axi_rready, icap_csib, busy, done, error, cmd_ready}),
          64'b0010001);
    check("v6_rst_icap_o", 64'(icap_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_cmd(34'h5000, 32'd0, 20, w);
    check("v6_len0_done",    64'(done_cnt), 64'd1);
    check("v6_len0_latency", 64'(w <= 2), 64'd1);
    check("v6_len0_nar",     64'(ar_addr_log.size()), 64'd0);
    check("v6_len0_nwords",  64'(got.size()), 64'd0);

    check("one_outstanding", 64'(ovl_viol), 64'd0);
    check("csib_idle_zero",  64'(csib_viol), 64'd0);
    check("rdwrb_low",       64'(icap_rdwrb), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/recon_icap_loader.md
RECON_ICAP_LOADER -- requirements
Module: recon_icap_loader

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
 DATA_WIDTH, 64, AXI read data width in bits (multiple of 32, max 512)
 ADDR_WIDTH, 34, AXI address width
 ID_WIDTH, 6, AXI ID width
 MAX_BURST_LEN, 16, maximum beats per AR burst (power of 2, 1-256)
REQ-002 SHALL have ports, one per line: name direction width meaning:
 clk input 1 single clock for all logic
 rst input 1 synchronous active-high reset
 cmd_addr input ADDR_WIDTH bitstream byte start address in memory
 cmd_len input 32 bitstream length in bytes
 cmd_valid input 1 command valid
 cmd_ready output 1 command accepted when high with cmd_valid
 m_axi_arid output ID_WIDTH constant 0
 m_axi_araddr output ADDR_WIDTH burst address
 m_axi_arlen output 8 beats minus 1
 m_axi_arsize output 3 log2(DATA_WIDTH/8)
 m_axi_arburst output 2 constant 2'b01 INCR
 m_axi_arvalid / m_axi_arready output/input 1 AR handshake
 m_axi_rdata input DATA_WIDTH read data
 m_axi_rresp input 2 read response
 m_axi_rlast input 1 last beat of burst
 m_axi_rvalid / m_axi_rready input/output 1 R handshake
 icap_csib output 1 ICAP chip select, active low
 icap_rdwrb output 1 ICAP direction, held 0 (write)
 icap_o output 32 ICAP write word
 icap_ready input 1 sink may accept a word this cycle
 busy output 1 command in progress
 done output 1 one-cycle pulse at command completion
 error output 1 sticky error flag, cleared on next accepted command
REQ-003 Clock and reset SHALL be one clock (clk) with synchronous active-high reset (rst), exactly as already decided.

Function
REQ-004 SHALL implement FSM states IDLE, ADDR, DATA, DONE, ERR.
REQ-005 IDLE: cmd_ready=1; on cmd_valid, latch addr/len, clear error, go to ADDR. If len==0, go to DONE instead. If cmd_addr[1:0]!=0 or cmd_len[1:0]!=0, go to ERR.
REQ-006 ADDR: assert arvalid with araddr=current address aligned down to DATA_WIDTH/8. Burst beats = min(MAX_BURST_LEN, beats remaining, beats to next 4 KiB boundary). arvalid and araddr SHALL stay stable until arready; then go to DATA.
REQ-007 Only one burst SHALL be outstanding at a time.
REQ-008 DATA: one beat SHALL be held in a beat buffer. rready=1 only when the buffer is empty. Each beat unpacks into DATA_WIDTH/32 words, lowest word first. One word SHALL be emitted per cycle in which icap_ready=1.
REQ-009 Words before the start offset in the first beat, and words beyond cmd_len in the last beat, SHALL NOT be emitted.
REQ-010 Each emitted word SHALL have its bit order reversed within each byte (bit 0 swaps with bit 7, per byte). icap_csib=0 only in cycles where a word is driven; otherwise icap_csib=1 and icap_o=0.
REQ-011 Word output latency: first word on icap_o SHALL appear 1 cycle after the R handshake of the beat carrying it.
REQ-012 After a beat with rlast is fully emitted: if bytes remain, go to ADDR with address advanced by the burst size; otherwise go to DONE.
REQ-013 rresp!=2'b00 on any beat: that beat and all later beats SHALL NOT be emitted. Remaining beats up to rlast SHALL be accepted (rready=1), then go to ERR.
REQ-014 DONE: pulse done for 1 cycle, return to IDLE. ERR: set error, pulse done for 1 cycle, return to IDLE.
REQ-015 busy=1 in every state except IDLE. cmd_ready=0 whenever busy=1. A cmd_valid while busy SHALL be ignored.
REQ-016 The byte counter SHALL be 32 bits. Address arithmetic SHALL wrap modulo 2^ADDR_WIDTH.

Reset
REQ-017 rst SHALL force IDLE on the next clk edge, including mid-burst, with these outputs: arvalid=0, rready=0, icap_csib=1, icap_o=0, busy=0, done=0, error=0, cmd_ready=1. The beat buffer SHALL be emptied.
REQ-018 After reset, R beats still in flight from the aborted burst are outside this block's scope; the system SHALL reset the interconnect together with this block.

Verification
REQ-019 Bench SHALL cover these scenarios:
 V1: DATA_WIDTH=64, addr=0x1000, len=64, icap_ready=1 -> one AR burst (araddr=0x1000, arlen=7); 16 words in order, each byte bit-reversed (byte 0x01 -> 0x80); then one done pulse; error=0.
 V2: addr=0x0FF8, len=32 -> two bursts split at the 4 KiB boundary: araddr 0x0FF8 with arlen=0, then araddr 0x1000 with arlen=2; 8 words emitted.
 V3: addr=0x1004, len=8 -> words 0x1004 and 0x1008 only; the upper word of beat 0x1008 is not emitted.
 V4: rresp=2'b10 on beat 2 of 8 -> exactly 2 words emitted (from beat 0); rready stays high until rlast; error=1; done pulses once.
 V5: icap_ready toggled 1/0 every cycle, len=256 -> all 64 words emitted, none duplicated; rready low while the beat buffer is full.
 V6: rst asserted mid-DATA -> next cycle matches REQ-017; a new command with len=0 -> done pulse within 2 cycles and no AR issued.
